// File: rtl/wshbn_line_master.sv
// Wishbone classic-cycle master that moves one cache line as LINE_WORDS single-word beats.
// Optional ACK watchdog is built when WSHBN_MASTER_TIMEOUT_EN is defined.
module wshbn_line_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned LINE_WORDS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic                             req_i,
  input  logic                             we_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] wline_i,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] rline_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic                             CYC_O,
  output logic                             STB_O,
  output logic                             WE_O,
  output logic [ADDR_WIDTH-1:0]            ADR_O,
  output logic [WORD_WIDTH-1:0]            DAT_O,
  input  logic [WORD_WIDTH-1:0]            DAT_I,
  input  logic                             ACK_I
);

  localparam int unsigned CNT_W  = $clog2(LINE_WORDS);
  localparam int unsigned LINE_W = LINE_WORDS * WORD_WIDTH;
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_WORDS - 1);

  if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("wshbn_line_master: LINE_WORDS must be a power of 2 >= 2 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    we_q, we_d;
  logic [LINE_W-1:0]       wline_q, wline_d;
  logic [LINE_W-1:0]       rline_q, rline_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [WORD_WIDTH-1:0]   dat_q, dat_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        beat;
  logic                    ack_live;

`ifdef WSHBN_MASTER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // The first XFER cycle only sets up the bus, so ACK counts only while STB_O is already out.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    we_d     = we_q;
    wline_d  = wline_q;
    rline_d  = rline_q;
    cyc_d    = 1'b0;
    stb_d    = 1'b0;
    wen_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    done_d   = 1'b0;
    beat     = cnt_q;
    ack_live = stb_q & ACK_I;
`ifdef WSHBN_MASTER_TIMEOUT_EN
    wd_d     = '0;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          base_d  = addr_i & ALIGN_MASK;
          we_d    = we_i;
          wline_d = wline_i;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        wen_d = we_q;
        if (ack_live) begin
          if (!we_q) begin
            rline_d[32'(cnt_q) * WORD_WIDTH +: WORD_WIDTH] = DAT_I;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            wen_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            beat  = cnt_d;
          end
        end
`ifdef WSHBN_MASTER_TIMEOUT_EN
        else if (stb_q) begin
          if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            wen_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
`endif
        adr_d = base_q + ADDR_WIDTH'(beat);
        dat_d = we_q ? wline_q[32'(beat) * WORD_WIDTH +: WORD_WIDTH] : '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      wline_q <= '0;
      rline_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WSHBN_MASTER_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      we_q    <= we_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WSHBN_MASTER_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rline_o = rline_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign CYC_O   = cyc_q;
  assign STB_O   = stb_q;
  assign WE_O    = wen_q;
  assign ADR_O   = adr_q;
  assign DAT_O   = dat_q;
`ifdef WSHBN_MASTER_TIMEOUT_EN
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wshbn_line_master.sv
// Randomized bench for wshbn_line_master: bus-level slave with random wait states and a line-level model.
module tb_wshbn_line_master;

  localparam int unsigned AW     = 32;
  localparam int unsigned WW     = 32;
  localparam int unsigned LWORDS = 4;
  localparam int unsigned LW     = LWORDS * WW;
  localparam int unsigned TO     = 8;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic          req_i;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [LW-1:0] wline_i;
  logic [LW-1:0] rline_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          CYC_O;
  logic          STB_O;
  logic          WE_O;
  logic [AW-1:0] ADR_O;
  logic [WW-1:0] DAT_O;
  logic [WW-1:0] DAT_I;
  logic          ACK_I;

  wshbn_line_master #(
    .ADDR_WIDTH    (AW),
    .WORD_WIDTH    (WW),
    .LINE_WORDS    (LWORDS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .req_i  (req_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .wline_i(wline_i),
    .rline_o(rline_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o),
    .CYC_O  (CYC_O),
    .STB_O  (STB_O),
    .WE_O   (WE_O),
    .ADR_O  (ADR_O),
    .DAT_O  (DAT_O),
    .DAT_I  (DAT_I),
    .ACK_I  (ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WW-1:0] mem [256];
  logic [LW-1:0] rline_model;
  logic [LW-1:0] wl;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one line request starting at a negedge; returns at a negedge with the DUT idle.
  task automatic do_line(input bit we, input logic [AW-1:0] addr, input logic [LW-1:0] wdat,
                         input int minw, input int maxw, input bit hold,
                         input int abort_at, input int stall_at);
    logic [AW-1:0] base;
    logic [LW-1:0] exp_r;
    int beat, waits, wsum, edges, stallc, outcome;
    base    = addr & ~AW'(LWORDS - 1);
    exp_r   = rline_model;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wline_i = wdat;
    ACK_I   = 1'b0;
    beat    = 0;
    stallc  = 0;
    outcome = 0;
    waits   = int'($urandom_range(maxw, minw));
    wsum    = waits;
    @(posedge CLK_I);
    edges = 1;
    for (int c = 0; c < 300 && outcome == 0; c++) begin
      @(negedge CLK_I);
      ACK_I = 1'b0;
      req_i = hold;
      if (hold) begin
        addr_i = AW'($urandom);
        we_i   = 1'($urandom);
      end
      if (done_o) begin
        outcome = 1;
        chk("done_err", LW'(err_o), LW'(stall_at >= 0));
        chk("done_cyc", LW'(CYC_O), LW'(0));
        chk("done_busy", LW'(busy_o), LW'(1));
        chk("done_beats", LW'(beat), LW'(stall_at >= 0 ? stall_at : int'(LWORDS)));
        if (stall_at >= 0) chk("timeout_len", LW'(stallc), LW'(TO));
        else chk("latency", LW'(edges), LW'(int'(LWORDS) + 2 + wsum));
        chk("rline", rline_o, exp_r);
      end else if (STB_O && beat == abort_at) begin
        RST_I = 1'b0;
        #1;
        chk("rst_cyc", LW'(CYC_O), LW'(0));
        chk("rst_stb", LW'(STB_O), LW'(0));
        chk("rst_busy", LW'(busy_o), LW'(0));
        chk("rst_rline", rline_o, LW'(0));
        outcome = 2;
      end else if (STB_O && beat == stall_at) begin
        stallc++;
        chk("stall_cyc", LW'(CYC_O), LW'(1));
`ifndef WSHBN_MASTER_TIMEOUT_EN
        if (stallc == 3 * int'(TO)) begin
          chk("stall_err", LW'(err_o), LW'(0));
          chk("stall_done", LW'(done_o), LW'(0));
          RST_I = 1'b0;
          #1;
          chk("stall_rst_cyc", LW'(CYC_O), LW'(0));
          outcome = 2;
        end
`endif
      end else if (STB_O) begin
        if (waits > 0) begin
          waits--;
        end else begin
          chk("adr", LW'(ADR_O), LW'(base + AW'(beat)));
          chk("we", LW'(WE_O), LW'(we));
          if (we) begin
            chk("dat", LW'(DAT_O), LW'(wdat[beat*WW +: WW]));
            mem[ADR_O[7:0]] = DAT_O;
          end else begin
            DAT_I = mem[ADR_O[7:0]];
            exp_r[beat*WW +: WW] = mem[8'(base + AW'(beat))];
          end
          ACK_I = 1'b1;
          beat++;
          if (beat < int'(LWORDS)) begin
            waits = int'($urandom_range(maxw, minw));
            wsum += waits;
          end
        end
      end
      if (outcome == 0) begin
        @(posedge CLK_I);
        edges++;
      end
    end
    chk("line_ended", LW'(outcome != 0), LW'(1));
    if (outcome == 2) begin
      @(negedge CLK_I);
      chk("rst_no_done", LW'(done_o), LW'(0));
      RST_I       = 1'b1;
      ACK_I       = 1'b0;
      req_i       = 1'b0;
      rline_model = '0;
    end else if (outcome == 1) begin
      rline_model = exp_r;
      ACK_I = 1'b1;
      DAT_I = $urandom;
      @(posedge CLK_I);
      @(negedge CLK_I);
      chk("pulse_once", LW'(done_o), LW'(0));
      chk("gap_busy", LW'(busy_o), LW'(0));
      chk("gap_cyc", LW'(CYC_O), LW'(0));
      chk("gap_rline", rline_o, rline_model);
      if (!hold) begin
        @(posedge CLK_I);
        @(negedge CLK_I);
        chk("idle_ack_busy", LW'(busy_o), LW'(0));
        chk("idle_ack_rline", rline_o, rline_model);
      end
      ACK_I = 1'b0;
    end
  endtask

  initial begin
    RST_I       = 1'b1;
    req_i       = 1'b0;
    we_i        = 1'b0;
    addr_i      = '0;
    wline_i     = '0;
    DAT_I       = '0;
    ACK_I       = 1'b0;
    rline_model = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #2 RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    chk("rst_cyc0", LW'(CYC_O), LW'(0));
    chk("rst_stb0", LW'(STB_O), LW'(0));
    chk("rst_we0", LW'(WE_O), LW'(0));
    chk("rst_busy0", LW'(busy_o), LW'(0));
    chk("rst_done0", LW'(done_o), LW'(0));
    chk("rst_err0", LW'(err_o), LW'(0));
    chk("rst_adr0", LW'(ADR_O), LW'(0));
    chk("rst_dat0", LW'(DAT_O), LW'(0));
    chk("rst_rline0", rline_o, LW'(0));
    RST_I = 1'b1;
    @(negedge CLK_I);

    for (int k = 0; k < int'(LWORDS); k++) wl[k*WW +: WW] = $urandom;
    do_line(1'b0, AW'('h13), wl, 2, 2, 1'b0, -1, -1);
    wl = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    do_line(1'b1, AW'('h20), wl, 0, 0, 1'b0, -1, -1);
    do_line(1'b0, AW'('h42), wl, 0, 1, 1'b1, -1, -1);
    do_line(1'b1, AW'('h47), ~wl, 0, 1, 1'b0, -1, -1);
    do_line(1'b0, AW'('h30), wl, 0, 0, 1'b0, 2, -1);
    do_line(1'b0, AW'('h35), wl, 0, 1, 1'b0, -1, -1);
    do_line(1'b0, AW'('h50), wl, 0, 0, 1'b0, -1, 1);
    do_line(1'b0, AW'('h11), wl, 0, 0, 1'b0, -1, -1);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < int'(LWORDS); k++) wl[k*WW +: WW] = $urandom;
      do_line(1'($urandom), AW'($urandom), wl, 0, int'($urandom_range(3, 0)),
              1'($urandom), -1, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wshbn_line_master.md
# wshbn_line_master

Wishbone classic-cycle master that moves one cache line between the cache controller and a Wishbone slave memory (e.g. the data RAM slave) as a sequence of single-word beats. It sits between the cache miss/writeback logic and the shared Wishbone bus. It accepts one line request at a time, issues `LINE_WORDS` word accesses at consecutive word addresses and returns the assembled read line or confirms the write.

## Interface
- `ADDR_WIDTH`, default 32: word address width, from `cache_parameters`.
- `WORD_WIDTH`, default 32: data word width, from `cache_parameters`.
- `LINE_WORDS`, default 4: words per line; must be a power of 2, ≥2.
- `TIMEOUT_CYCLES`, default 255: ACK watchdog limit; used only with the timeout feature.
- `CLK_I`  in  1  clock; all logic is on the rising edge.
- `RST_I`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  line request; sampled only in IDLE.
- `we_i`  in  1  1 = write line, 0 = read line.
- `addr_i`  in  ADDR_WIDTH  line word address; the low log2(LINE_WORDS) bits are forced to 0.
- `wline_i`  in  LINE_WORDS*WORD_WIDTH  write line; word k is at bits [k*WORD_WIDTH +: WORD_WIDTH].
- `rline_o`  out  LINE_WORDS*WORD_WIDTH  read line, with the same packing.
- `busy_o`  out  1  high when the state is not IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  timeout flag, qualified by `done_o`.
- `CYC_O`, `STB_O`, `WE_O`  out  1  Wishbone cycle, strobe and write enable.
- `ADR_O`  out  ADDR_WIDTH  Wishbone address.
- `DAT_O`  out  WORD_WIDTH  Wishbone write data.
- `DAT_I`  in  WORD_WIDTH  Wishbone read data.
- `ACK_I`  in  1  Wishbone acknowledge.

## Operation
- States are IDLE, XFER and DONE. All outputs are registered.
- **IDLE**
  - When `req_i`=1: latch the aligned address, `we_i` and `wline_i`; clear the beat counter `cnt`; go to XFER.
- **XFER**
  - Outputs: `CYC_O`=`STB_O`=1, `WE_O` = latched we, `ADR_O` = base+`cnt`, `DAT_O` = wline word `cnt` (0 on reads).
  - On a cycle with `ACK_I`=1 and a read: store `DAT_I` into `rline_o` word `cnt`.
  - On `ACK_I` with `cnt` < LINE_WORDS-1: `cnt`++. `ADR_O`/`DAT_O` update on the next cycle; `CYC_O`/`STB_O` stay high between beats.
  - On `ACK_I` with `cnt` = LINE_WORDS-1: go to DONE.
- **DONE**
  - Outputs: `CYC_O`=`STB_O`=`WE_O`=0, `done_o`=1, `busy_o`=1. Next state is IDLE.
- `req_i` is ignored in XFER and DONE; requests are not queued.
- `ACK_I` is ignored outside XFER.
- `rline_o` holds its value until the next read beat overwrites a word. Write transfers never modify it.
- Address arithmetic is modulo 2^ADDR_WIDTH. Alignment guarantees `cnt` never carries out of the line.

## Timing
- Reset values: `CYC_O`, `STB_O`, `WE_O`, `busy_o`, `done_o`, `err_o` = 0; `ADR_O`, `DAT_O`, `rline_o` = 0; state = IDLE; `cnt` = 0.
- Reset is asynchronous and takes effect immediately, including mid-transfer. No `done_o` is produced for an aborted line.
- If `req_i` is sampled at edge N, then `CYC_O`/`STB_O`/`ADR_O` are valid after edge N+1.
- Each beat lasts 1 + (slave wait states) cycles. The next address is presented on the cycle after the ACK edge.
- `done_o` and the `CYC_O` drop occur one cycle after the final ACK is sampled.
- Minimum idle gap between lines: `req_i` is sampled again in the cycle after DONE.
- Total latency with zero-wait ACK: LINE_WORDS + 2 cycles from the `req_i` edge to `done_o`.

## Configuration
- `WSHBN_MASTER_TIMEOUT_EN` defined:
  - A watchdog counts consecutive XFER cycles without `ACK_I`; it resets on each ACK.
  - When the count reaches TIMEOUT_CYCLES: go to DONE with `err_o`=1 and `done_o`=1, and deassert `CYC_O`/`STB_O`. The partial `rline_o` is retained.
- `WSHBN_MASTER_TIMEOUT_EN` not defined:
  - No watchdog hardware; `err_o` is tied to 0.
  - XFER waits indefinitely for `ACK_I`.

## Test plan
- Read line, LINE_WORDS=4, `addr_i`=0x13, slave ACK after 2 wait states:
  - `ADR_O` sequence is 0x10, 0x11, 0x12, 0x13; `WE_O`=0 throughout.
  - `rline_o` = {D3,D2,D1,D0}; a single `done_o` pulse; `err_o`=0.
- Write line `wline_i`={0xDDDD,0xCCCC,0xBBBB,0xAAAA}, `addr_i`=0x20, zero-wait ACK:
  - `DAT_O` sequence is 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD at 0x20..0x23.
  - `done_o` arrives exactly 6 cycles after the `req_i` edge; `rline_o` is unchanged.
- `req_i` held high during a transfer and asserted again in DONE:
  - Only the first line runs until IDLE; the second starts exactly one cycle after DONE.
- `RST_I` pulled low during beat 2 of a read:
  - `CYC_O`, `STB_O` and `busy_o` fall immediately; `rline_o`=0; no `done_o`.
  - After release, a new request completes normally.
- Spurious `ACK_I`=1 in IDLE and DONE: no state change, no data capture.
- With the macro, TIMEOUT_CYCLES=8 and ACK withheld on beat 1:
  - After 8 cycles: `done_o`=1, `err_o`=1, `CYC_O`=0.
  - Without the macro, the same stimulus keeps `CYC_O`=1 indefinitely with `err_o`=0.
